// File: rtl/cdda_pkg.sv
// Shared constants, FSM state type and saturation helper for the CDDA mixer.
package cdda_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned GAIN_W     = 9;
    localparam int unsigned GAIN_UNITY = 256;

    typedef enum logic [1:0] {
        StIdle,
        StMulL,
        StMulR,
        StOut
    } mix_state_e;

    // The sum has one extra bit; overflow shows as the top two bits disagreeing.
    function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
            return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/cdda_gain_ramp.sv
// Volume/mute target mapping and the click-free gain ramp register.
module cdda_gain_ramp
    import cdda_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 1,
    parameter int unsigned INIT_GAIN = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              update_i,
    input  logic [7:0]        vol_i,
    input  logic              mute_i,
    output logic [GAIN_W-1:0] gain_o
);

    localparam logic [GAIN_W:0]   Step     = RAMP_STEP[GAIN_W:0];
    localparam logic [GAIN_W-1:0] InitGain = INIT_GAIN[GAIN_W-1:0];
    localparam logic [GAIN_W-1:0] Unity    = GAIN_UNITY[GAIN_W-1:0];

    logic [GAIN_W-1:0] target;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W:0]   up_sum;
    logic [GAIN_W:0]   down_floor;

    always_comb begin
        if (mute_i) begin
            target = '0;
        end else if (vol_i == 8'hFF) begin
            target = Unity;
        end else begin
            target = {1'b0, vol_i};
        end

        up_sum     = {1'b0, gain_q} + Step;
        down_floor = {1'b0, target} + Step;

        gain_d = gain_q;
        if (update_i) begin
            // Clamp at the target so a coarse step never overshoots.
            if (gain_q < target) begin
                gain_d = (up_sum > {1'b0, target}) ? target : up_sum[GAIN_W-1:0];
            end else if (gain_q > target) begin
                gain_d = ({1'b0, gain_q} > down_floor) ? gain_q - Step[GAIN_W-1:0] : target;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            gain_q <= InitGain;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain_o = gain_q;

endmodule

// File: rtl/cdda_mixer.sv
// CDDA volume/mute ramp, mix with core audio and saturate; one shared multiplier.
// Optional saturation counter enabled by defining CDDA_CLIP_CNT_EN.
module cdda_mixer
    import cdda_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 1,
    parameter int unsigned INIT_GAIN = 0
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                cen_44100,
    input  logic [SAMPLE_W-1:0] cdda_l,
    input  logic [SAMPLE_W-1:0] cdda_r,
    input  logic [SAMPLE_W-1:0] core_l,
    input  logic [SAMPLE_W-1:0] core_r,
    input  logic [7:0]          cdda_vol,
    input  logic                cdda_mute,
    output logic [SAMPLE_W-1:0] audio_l,
    output logic [SAMPLE_W-1:0] audio_r,
    output logic                out_valid
`ifdef CDDA_CLIP_CNT_EN
    ,
    output logic [15:0]         clip_count
`endif
);

    mix_state_e state_q, state_d;

    logic                capture;
    logic [GAIN_W-1:0]   gain;
    logic [SAMPLE_W-1:0] cdda_l_q, cdda_r_q, core_l_q, core_r_q;
    logic [SAMPLE_W-1:0] res_l_q, res_l_d, res_r_q, res_r_d;
    logic [SAMPLE_W-1:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic                out_valid_q, out_valid_d;

    logic [SAMPLE_W-1:0] mul_sample, mul_core;
    logic [25:0]         mul_a, mul_b;
    logic signed [25:0]  product;
    logic [SAMPLE_W-1:0] scaled;
    logic [SAMPLE_W:0]   sum;
    logic [SAMPLE_W-1:0] sat_val;
    logic                clip;
    logic                unused_prod;

    assign capture = (state_q == StIdle) && cen_44100;

    cdda_gain_ramp #(
        .RAMP_STEP (RAMP_STEP),
        .INIT_GAIN (INIT_GAIN)
    ) u_gain_ramp (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .update_i (capture),
        .vol_i    (cdda_vol),
        .mute_i   (cdda_mute),
        .gain_o   (gain)
    );

    // Shared multiplier: left channel in StMulL, right in StMulR.
    always_comb begin
        mul_sample = (state_q == StMulR) ? cdda_r_q : cdda_l_q;
        mul_core   = (state_q == StMulR) ? core_r_q : core_l_q;
        mul_a      = {{(26 - SAMPLE_W){mul_sample[SAMPLE_W-1]}}, mul_sample};
        mul_b      = {{(26 - GAIN_W){1'b0}}, gain};
        product    = $signed(mul_a) * $signed(mul_b);
        // Gain never exceeds unity, so the >>>8 result always fits 16 bits.
        scaled     = product[SAMPLE_W+7:8];
        sum        = {scaled[SAMPLE_W-1], scaled} + {mul_core[SAMPLE_W-1], mul_core};
        sat_val    = sat16(sum);
        clip       = sum[SAMPLE_W] ^ sum[SAMPLE_W-1];
    end

    assign unused_prod = ^{product[25:SAMPLE_W+8], product[7:0]};

    always_comb begin
        state_d     = state_q;
        res_l_d     = res_l_q;
        res_r_d     = res_r_q;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cen_44100) begin
                    state_d = StMulL;
                end
            end
            StMulL: begin
                state_d = StMulR;
                res_l_d = sat_val;
            end
            StMulR: begin
                state_d = StOut;
                res_r_d = sat_val;
            end
            StOut: begin
                state_d     = StIdle;
                audio_l_d   = res_l_q;
                audio_r_d   = res_r_q;
                out_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cdda_l_q    <= '0;
            cdda_r_q    <= '0;
            core_l_q    <= '0;
            core_r_q    <= '0;
            res_l_q     <= '0;
            res_r_q     <= '0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_l_q     <= res_l_d;
            res_r_q     <= res_r_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            out_valid_q <= out_valid_d;
            if (capture) begin
                cdda_l_q <= cdda_l;
                cdda_r_q <= cdda_r;
                core_l_q <= core_l;
                core_r_q <= core_r;
            end
        end
    end

    assign audio_l   = audio_l_q;
    assign audio_r   = audio_r_q;
    assign out_valid = out_valid_q;

`ifdef CDDA_CLIP_CNT_EN
    logic        clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic [15:0] clip_cnt_q, clip_cnt_d;
    logic [16:0] clip_sum;

    always_comb begin
        clip_l_d   = (state_q == StMulL) ? clip : clip_l_q;
        clip_r_d   = (state_q == StMulR) ? clip : clip_r_q;
        clip_sum   = {1'b0, clip_cnt_q} + 17'(clip_l_q) + 17'(clip_r_q);
        clip_cnt_d = clip_cnt_q;
        if (state_q == StOut) begin
            clip_cnt_d = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clip_l_q   <= 1'b0;
            clip_r_q   <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            clip_l_q   <= clip_l_d;
            clip_r_q   <= clip_r_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_count = clip_cnt_q;
`else
    logic unused_clip;
    assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_cdda_mixer.sv
// Directed, table-driven bench for cdda_mixer: instance A (step 1, init 0), B (step 4, init 256).
module tb_cdda_mixer;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n, cen_44100, cdda_mute;
    logic [15:0] cdda_l, cdda_r, core_l, core_r;
    logic [7:0]  cdda_vol;
    logic [15:0] audio_l_a, audio_r_a, audio_l_b, audio_r_b;
    logic        out_valid_a, out_valid_b;
`ifdef CDDA_CLIP_CNT_EN
    logic [15:0] clip_count_a, clip_count_b;
`endif

    int checks = 0;
    int errors = 0;

    cdda_mixer #(.RAMP_STEP(1), .INIT_GAIN(0)) dut_a (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cen_44100  (cen_44100),
        .cdda_l     (cdda_l),
        .cdda_r     (cdda_r),
        .core_l     (core_l),
        .core_r     (core_r),
        .cdda_vol   (cdda_vol),
        .cdda_mute  (cdda_mute),
        .audio_l    (audio_l_a),
        .audio_r    (audio_r_a),
        .out_valid  (out_valid_a)
`ifdef CDDA_CLIP_CNT_EN
        ,
        .clip_count (clip_count_a)
`endif
    );

    cdda_mixer #(.RAMP_STEP(4), .INIT_GAIN(256)) dut_b (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cen_44100  (cen_44100),
        .cdda_l     (cdda_l),
        .cdda_r     (cdda_r),
        .core_l     (core_l),
        .core_r     (core_r),
        .cdda_vol   (cdda_vol),
        .cdda_mute  (cdda_mute),
        .audio_l    (audio_l_b),
        .audio_r    (audio_r_b),
        .out_valid  (out_valid_b)
`ifdef CDDA_CLIP_CNT_EN
        ,
        .clip_count (clip_count_b)
`endif
    );

    typedef struct packed {
        logic [15:0] cl;
        logic [15:0] cr;
        logic [15:0] kl;
        logic [15:0] kr;
        logic [7:0]  vol;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs[8];

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One strobe; checks the N+3 latency and the single-cycle pulse on both instances.
    task automatic strobe(input string nm);
        int lat;
        lat = 0;
        @(negedge clk_sys) cen_44100 = 1'b1;
        @(negedge clk_sys) cen_44100 = 1'b0;
        while (!out_valid_a && lat < 8) begin
            @(negedge clk_sys);
            lat++;
        end
        checks++;
        if (lat != 3 || out_valid_b !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (b valid %b) expected 3 (b valid 1)",
                     nm, lat, out_valid_b);
        end
        @(negedge clk_sys);
        check16({nm, "_pulse"}, {14'd0, out_valid_a, out_valid_b}, 16'd0);
    endtask

    task automatic set_in(input logic [15:0] cl, input logic [15:0] cr, input logic [15:0] kl,
                          input logic [15:0] kr, input logic [7:0] vol, input logic mute);
        cdda_l    = cl;
        cdda_r    = cr;
        core_l    = kl;
        core_r    = kr;
        cdda_vol  = vol;
        cdda_mute = mute;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            set_in(vecs[i].cl, vecs[i].cr, vecs[i].kl, vecs[i].kr, vecs[i].vol, 1'b0);
            strobe($sformatf("vec%0d", i));
            check16($sformatf("vec%0d_l", i), audio_l_a, vecs[i].el);
            check16($sformatf("vec%0d_r", i), audio_r_a, vecs[i].er);
`ifdef CDDA_CLIP_CNT_EN
            if (i == 0) check16("clip_count_both", clip_count_a, 16'd2);
`endif
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic seen;
        // Gain 256 (vectors 0-3) then gain 128 (vectors 4-7).
        vecs[0] = '{16'h7000, 16'h9000, 16'h2000, 16'hE000, 8'hFF, 16'h7FFF, 16'h8000};
        vecs[1] = '{16'h1234, 16'h8000, 16'h0100, 16'h0000, 8'hFF, 16'h1334, 16'h8000};
        vecs[2] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 8'hFF, 16'h7FFF, 16'h8000};
        vecs[3] = '{16'h4000, 16'h7FFF, 16'hC000, 16'h8000, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 8'h80, 16'hFFFF, 16'hC000};
        vecs[5] = '{16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 8'h80, 16'h0000, 16'h3FFF};
        vecs[6] = '{16'hFFFE, 16'h0003, 16'h0000, 16'h0000, 8'h80, 16'hFFFF, 16'h0001};
        vecs[7] = '{16'h0100, 16'h8001, 16'h7FF0, 16'h8000, 8'h80, 16'h7FFF, 16'h8000};

        reset_n   = 1'b0;
        cen_44100 = 1'b0;
        set_in(16'h4000, 16'h2000, 16'h0000, 16'h0000, 8'hFF, 1'b0);
        repeat (3) @(negedge clk_sys);
        check16("reset_audio_l", audio_l_a, 16'h0000);
        check16("reset_audio_r", audio_r_a, 16'h0000);
        check16("reset_valid", {14'd0, out_valid_a, out_valid_b}, 16'd0);
        check16("reset_audio_l_b", audio_l_b, 16'h0000);
        reset_n = 1'b1;

        // Fade in from gain 0 at unity target.
        for (int k = 1; k <= 256; k++) begin
            strobe($sformatf("fadein%0d", k));
            check16($sformatf("fadein%0d_l", k), audio_l_a, 16'(k * 64));
            check16($sformatf("fadein%0d_r", k), audio_r_a, 16'(k * 32));
        end
        strobe("unity_hold");
        check16("unity_hold_l", audio_l_a, 16'h4000);

        apply_vecs(0, 3);

        // Mute fades out, one step per strobe, then stays silent.
        set_in(16'h4000, 16'h2000, 16'h0000, 16'h0000, 8'hFF, 1'b1);
        for (int k = 1; k <= 256; k++) begin
            strobe($sformatf("mute%0d", k));
            check16($sformatf("mute%0d_l", k), audio_l_a, 16'((256 - k) * 64));
            check16($sformatf("mute%0d_r", k), audio_r_a, 16'((256 - k) * 32));
        end
        strobe("mute_hold");
        check16("mute_hold_l", audio_l_a, 16'h0000);

        set_in(16'h4000, 16'h2000, 16'h0000, 16'h0000, 8'h80, 1'b0);
        for (int k = 1; k <= 128; k++) begin
            strobe($sformatf("half%0d", k));
            check16($sformatf("half%0d_l", k), audio_l_a, 16'(k * 64));
        end

        apply_vecs(4, 7);

        // Reset in the cycle after the strobe aborts the sample.
        set_in(16'h4000, 16'h2000, 16'h0000, 16'h0000, 8'hFF, 1'b0);
        @(negedge clk_sys) cen_44100 = 1'b1;
        @(negedge clk_sys) cen_44100 = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_sys);
        check16("abort_audio_l", audio_l_a, 16'h0000);
        check16("abort_audio_r", audio_r_a, 16'h0000);
        check16("abort_audio_l_b", audio_l_b, 16'h0000);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_sys);
            if (out_valid_a || out_valid_b) seen = 1'b1;
        end
        check16("abort_no_valid", {15'd0, seen}, 16'd0);
        strobe("post_reset");
        check16("post_reset_l", audio_l_a, 16'h0040);
        check16("post_reset_r", audio_r_a, 16'h0020);
        check16("post_reset_l_b", audio_l_b, 16'h4000);

        // B ramps 256 -> 128 in steps of 4; A keeps climbing by 1.
        cdda_vol = 8'h80;
        for (int k = 1; k <= 32; k++) begin
            strobe($sformatf("step4_%0d", k));
            check16($sformatf("step4_%0d_b", k), audio_l_b, 16'((256 - 4 * k) * 64));
            check16($sformatf("step4_%0d_a", k), audio_l_a, 16'((1 + k) * 64));
        end
        for (int j = 0; j < 2; j++) begin
            strobe($sformatf("step4_hold%0d", j));
            check16($sformatf("step4_hold%0d_b", j), audio_l_b, 16'h2000);
            check16($sformatf("step4_hold%0d_a", j), audio_l_a, 16'((34 + j) * 64));
        end

        // Target drops below both gains mid-ramp: both redirect from where they are.
        cdda_vol = 8'h10;
        strobe("redirect");
        check16("redirect_a", audio_l_a, 16'h0880);
        check16("redirect_b", audio_l_b, 16'h1F00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdda_mixer.md
Name: cdda_mixer

Overview:
Downstream stage of the CDDA FIFO. It consumes the 44.1 kHz cdda_l/cdda_r sample pair and applies a click-free ramped volume and mute. It then sums the result with the core's own audio, saturates, and presents one registered stereo sample per cen_44100 to the audio DAC path. The multiply is time-multiplexed through one multiplier (left, then right) by a small FSM.

Parameters:
RAMP_STEP, 1, gain change per sample toward target (1..256); 256 steps at 1 ≈ 5.8 ms full fade
INIT_GAIN, 0, gain register value after reset (0..256)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cen_44100  in  1  one-cycle sample strobe, at least 4 clk_sys cycles apart
cdda_l  in  16  signed CDDA left sample, sampled on cen_44100
cdda_r  in  16  signed CDDA right sample, sampled on cen_44100
core_l  in  16  signed core audio left, sampled on cen_44100
core_r  in  16  signed core audio right, sampled on cen_44100
cdda_vol  in  8  target volume; 255 maps to unity (256), else gain target = value
cdda_mute  in  1  forces gain target to 0; fade, not hard cut
audio_l  out  16  signed mixed left, registered
audio_r  out  16  signed mixed right, registered
out_valid  out  1  one-cycle pulse when audio_l/audio_r update
clip_count  out  16  saturation event counter (only with CDDA_CLIP_CNT_EN)

Behaviour:
- Async reset (reset_n=0): FSM=IDLE, gain=INIT_GAIN, audio_l/audio_r=0, out_valid=0, capture regs=0, clip_count=0. Reset mid-sequence aborts the sample; no out_valid is issued for it.
- FSM states: IDLE, MUL_L, MUL_R, OUT.
  - IDLE→MUL_L on cen_44100.
  - MUL_L→MUL_R, MUL_R→OUT, OUT→IDLE unconditionally.
  - cen_44100 outside IDLE is ignored.
- IDLE on cen_44100:
  - Capture cdda_l, cdda_r, core_l, core_r.
  - Compute target = cdda_mute ? 0 : (cdda_vol==255 ? 256 : cdda_vol).
  - Update 9-bit gain: if gain<target, gain=min(gain+RAMP_STEP, target); if gain>target, gain=max(gain-RAMP_STEP, target); else hold.
  - The updated gain applies to this same sample.
- MUL_L/MUL_R:
  - scaled = (sample × gain) >>> 8. Signed 16 × unsigned 9 gives a 26-bit signed product; the shift is arithmetic and truncates toward −inf. gain=256 reproduces the sample exactly.
  - sum = scaled + core (17-bit signed).
  - Saturate to [−32768, 32767] into a result reg.
- OUT: audio_l/audio_r load the results and out_valid=1 for this cycle only.
- Latency: cen_44100 in cycle N → out_valid and new outputs visible after edge N+3, held until the next update.
- Target change mid-ramp: the ramp redirects from the current gain; no jump.

Optional Feature:
CDDA_CLIP_CNT_EN
- Defined: clip_count increments by 1 for each channel that saturates (so +2 if both channels clip in one sample). It sticks at 0xFFFF and is cleared only by reset.
- Undefined: clip_count port and counter are absent; the datapath is otherwise identical.

Decomposition:
- Package cdda_pkg:
  - SAMPLE_W=16, GAIN_W=9, GAIN_UNITY=256
  - FSM state enum
  - sat16 function (17-bit signed → 16-bit saturated)
- Sub-module cdda_gain_ramp holds target mapping, ramp step and gain register.
- The mixer FSM and shared multiplier stay in cdda_mixer.

Test Plan:
1. Reset with INIT_GAIN=0, vol=255, mute=0, cdda_l=0x4000, core=0 → first sample audio_l=0x0040 (gain 1); after 256 strobes audio_l=0x4000 and gain holds.
2. Gain 256, cdda_l=0x7000, core_l=0x2000 and cdda_r=0x9000, core_r=0xE000 → audio_l=0x7FFF, audio_r=0x8000; clip_count +2 with CDDA_CLIP_CNT_EN.
3. Gain 256, cdda_l=0x4000, assert mute → next audio_l=0x3FC0, then decreasing each strobe; reaches 0 after exactly 256 strobes, stays 0.
4. Gain 128, cdda_l=0xFFFF (−1), core=0 → audio_l=0xFFFF (truncation toward −inf); cdda_l=0x0001 → 0x0000.
5. cen_44100 in cycle N → out_valid high only at N+3; pulse reset_n low at N+1 → outputs 0, no out_valid, gain=INIT_GAIN.
6. Gain 256, vol changed to 0x80 with RAMP_STEP=4 → gain reaches 128 after exactly 32 strobes, no overshoot.
